// File: rtl/controle_ula_multiciclo.sv
// Multicycle control FSM for the 8-bit Nrisc datapath.
// It decodes the latched opcode and drives the ULA operation, the ULA operand selects and the
// datapath enables. It also handshakes with memory and halts if memory stops responding.
module controle_ula_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ULAOp,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       erro_mem
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StWbUla, StAddr,
        StMem, StWbMem, StBranch, StJump, StHalt
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            erro_q;

    logic            is_lw;
    logic            is_imm;
    logic [2:0]      ula_exec;

    assign is_lw  = (opcode == 4'h8);
    assign is_imm = (opcode >= 4'h5) && (opcode <= 4'h7);

    // ULA operation for R and I arithmetic; R opcodes map directly onto the ULA encoding.
    always_comb begin
        ula_exec = 3'b000;
        if (opcode <= 4'h4) begin
            ula_exec = opcode[2:0];
        end else if (opcode == 4'h6) begin
            ula_exec = 3'b001;
        end else if (opcode == 4'h7) begin
            ula_exec = 3'b100;
        end
    end

    // State sequencing, memory wait counter and the sticky timeout flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch, StMem: begin
                    if (mem_ready) begin
                        cnt_q <= '0;
                        if (state_q == StFetch) begin
                            state_q <= StDecode;
                        end else begin
                            state_q <= is_lw ? StWbMem : StFetch;
                        end
                    end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
                        cnt_q   <= '0;
                        erro_q  <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDecode: begin
                    if (opcode <= 4'h4) begin
                        state_q <= StExecR;
                    end else if (opcode <= 4'h7) begin
                        state_q <= StExecI;
                    end else if (opcode <= 4'h9) begin
                        state_q <= StAddr;
                    end else if (opcode <= 4'hB) begin
                        state_q <= StBranch;
                    end else if (opcode == 4'hC) begin
                        state_q <= StJump;
                    end else begin
                        // 0xD/0xE are illegal and stop the machine just like halt.
                        state_q <= StHalt;
                    end
                end
                StExecR, StExecI: state_q <= StWbUla;
                StAddr: begin
                    cnt_q   <= '0;
                    state_q <= StMem;
                end
                StWbUla, StWbMem, StBranch, StJump: begin
                    cnt_q   <= '0;
                    state_q <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Output decode; everything is forced low while reset is held so nothing is issued then.
    always_comb begin
        ULAOp      = 3'b000;
        ula_src_a  = 1'b0;
        ula_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        if (resetn) begin
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    ula_src_b = 2'b01;
                    pc_write  = mem_ready;
                end
                StDecode: ;
                StExecR, StExecI, StWbUla: begin
                    ULAOp     = ula_exec;
                    ula_src_a = 1'b1;
                    ula_src_b = is_imm ? 2'b10 : 2'b00;
                    reg_write = (state_q == StWbUla);
                end
                StAddr, StMem: begin
                    ula_src_a = 1'b1;
                    ula_src_b = 2'b10;
                    mem_read  = (state_q == StMem) && is_lw;
                    mem_write = (state_q == StMem) && !is_lw;
                end
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StBranch: begin
                    ULAOp     = 3'b001;
                    ula_src_a = 1'b1;
                    // opcode[0] distinguishes bne (0xB) from beq (0xA).
                    pc_write  = opcode[0] ? !zero : zero;
                end
                StJump: begin
                    pc_src   = 1'b1;
                    pc_write = 1'b1;
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign erro_mem = erro_q;

endmodule

// File: tb/tb_controle_ula_multiciclo.sv
// Randomized scoreboard bench for controle_ula_multiciclo.
// The stimulus walks whole instructions and queues the expected per-cycle outputs.
// A monitor pops one entry each falling edge and compares it under a mask.
module tb_controle_ula_multiciclo;

    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [2:0] ulaop;
        logic       src_a;
        logic [1:0] src_b;
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halted;
        logic       erro_mem;
    } outv_t;

    typedef struct {
        outv_t val;
        outv_t mask;
        string name;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ULAOp;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write;
    logic       reg_write, mem_to_reg, halted, erro_mem;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    outv_t m_en, m_ula, m_all;

    controle_ula_multiciclo #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ULAOp      (ULAOp),
        .ula_src_a  (ula_src_a),
        .ula_src_b  (ula_src_b),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .erro_mem   (erro_mem)
    );

    always #5 clock = ~clock;

    // Monitor: one expected entry per cycle, compared on the falling edge.
    always @(negedge clock) begin
        outv_t got;
        exp_t  e;
        got = {ULAOp, ula_src_a, ula_src_b, pc_write, pc_src, ir_write, mem_read,
               mem_write, reg_write, mem_to_reg, halted, erro_mem};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (((got ^ e.val) & e.mask) != '0) begin
                failures++;
                $display("FAIL %s t=%0t got=%h expected=%h mask=%h", e.name, $time, got,
                         e.val, e.mask);
            end
            checks++;
            if ((mem_read && mem_write) || (reg_write && pc_write)) begin
                failures++;
                $display("FAIL exclusive_enables t=%0t got=%h expected no overlap", $time, got);
            end
        end
    end

    function automatic logic [2:0] ref_ulaop(input logic [3:0] op);
        case (op)
            4'h0, 4'h5: return 3'b000;  // add, addi
            4'h1, 4'h6: return 3'b001;  // sub, subi
            4'h2:       return 3'b010;  // srl
            4'h3:       return 3'b011;  // sll
            4'h4, 4'h7: return 3'b100;  // slt, slti
            default:    return 3'b000;
        endcase
    endfunction

    // Apply inputs for one cycle, queue its expectation, advance to just after the next edge.
    task automatic step(input logic [3:0] op, input logic z, input logic rdy, input outv_t v,
                        input outv_t m, input string nm);
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back('{val: v, mask: m, name: nm});
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(4'($urandom), 1'($urandom), 1'($urandom), '0, m_all, "reset_low0");
        step(4'($urandom), 1'($urandom), 1'($urandom), '0, m_all, "reset_low1");
        resetn = 1'b1;
    endtask

    task automatic halted_cycles(input logic err, input string nm);
        outv_t v;
        v = '0;
        v.halted   = 1'b1;
        v.erro_mem = err;
        for (int i = 0; i < 3; i++) step(4'($urandom), 1'($urandom), 1'($urandom), v, m_en, nm);
        do_reset();
    endtask

    // Fetch with sf wait states (sf >= TIMEOUT forces a timeout); returns 1 if it halted.
    task automatic fetch(input int sf, output bit died);
        outv_t v;
        v = '0;
        v.mem_read = 1'b1;
        v.ir_write = 1'b1;
        v.src_b    = 2'b01;
        died = 1'b0;
        for (int i = 0; i < sf && i < int'(TIMEOUT); i++)
            step(4'($urandom), 1'($urandom), 1'b0, v, m_ula, "fetch_wait");
        if (sf >= int'(TIMEOUT)) begin
            died = 1'b1;
            halted_cycles(1'b1, "fetch_timeout");
        end else begin
            v.pc_write = 1'b1;
            step(4'($urandom), 1'($urandom), 1'b1, v, m_ula, "fetch_ready");
        end
    endtask

    // One complete instruction: sm wait states in MEM, abort = reset during the first MEM cycle.
    task automatic run_instr(input logic [3:0] op, input int sf, input int sm, input logic z,
                             input bit abort);
        outv_t v;
        bit    died;
        fetch(sf, died);
        if (died) return;
        step(op, 1'($urandom), 1'($urandom), '0, m_en, "decode");
        v = '0;
        if (op <= 4'h7) begin
            v.ulaop = ref_ulaop(op);
            v.src_a = 1'b1;
            v.src_b = (op >= 4'h5) ? 2'b10 : 2'b00;
            step(op, 1'($urandom), 1'($urandom), v, m_ula, "exec");
            v.reg_write = 1'b1;
            step(op, 1'($urandom), 1'($urandom), v, m_ula, "wb_ula");
        end else if (op <= 4'h9) begin
            v.src_a = 1'b1;
            v.src_b = 2'b10;
            step(op, 1'($urandom), 1'($urandom), v, m_ula, "addr");
            v.mem_read  = (op == 4'h8);
            v.mem_write = (op == 4'h9);
            if (abort) begin
                step(op, 1'($urandom), 1'b0, v, m_ula, "mem_before_abort");
                do_reset();
                return;
            end
            for (int i = 0; i < sm && i < int'(TIMEOUT); i++)
                step(op, 1'($urandom), 1'b0, v, m_ula, "mem_wait");
            if (sm >= int'(TIMEOUT)) begin
                halted_cycles(1'b1, "mem_timeout");
                return;
            end
            step(op, 1'($urandom), 1'b1, v, m_ula, "mem_ready");
            if (op == 4'h8) begin
                v = '0;
                v.reg_write  = 1'b1;
                v.mem_to_reg = 1'b1;
                step(op, 1'($urandom), 1'($urandom), v, m_en, "wb_mem");
            end
        end else if (op <= 4'hB) begin
            v.ulaop    = 3'b001;
            v.src_a    = 1'b1;
            v.pc_write = (op == 4'hA) ? z : ~z;
            step(op, z, 1'($urandom), v, m_ula, (op == 4'hA) ? "beq" : "bne");
        end else if (op == 4'hC) begin
            v.pc_src   = 1'b1;
            v.pc_write = 1'b1;
            step(op, 1'($urandom), 1'($urandom), v, m_en | outv_t'(15'h0040), "jump");
        end else begin
            halted_cycles(1'b0, "halt");
        end
    endtask

    initial begin
        m_all = '1;
        m_en = '0;
        m_en.pc_write   = 1'b1;
        m_en.ir_write   = 1'b1;
        m_en.mem_read   = 1'b1;
        m_en.mem_write  = 1'b1;
        m_en.reg_write  = 1'b1;
        m_en.mem_to_reg = 1'b1;
        m_en.halted     = 1'b1;
        m_en.erro_mem   = 1'b1;
        m_ula = m_en;
        m_ula.ulaop  = 3'b111;
        m_ula.src_a  = 1'b1;
        m_ula.src_b  = 2'b11;
        m_ula.pc_src = 1'b1;

        @(posedge clock);
        #1;
        do_reset();
        // Directed cases first.
        run_instr(4'h0, 0, 0, 1'b0, 1'b0);         // add, no wait states
        run_instr(4'h8, 0, 3, 1'b0, 1'b0);         // lw, 3-cycle memory stall
        run_instr(4'hA, 0, 0, 1'b1, 1'b0);         // beq taken
        run_instr(4'hB, 0, 0, 1'b1, 1'b0);         // bne not taken
        run_instr(4'hA, 1, 0, 1'b0, 1'b0);         // beq not taken
        run_instr(4'hC, 0, 0, 1'b0, 1'b0);         // j
        run_instr(4'h0, TIMEOUT, 0, 1'b0, 1'b0);   // fetch timeout
        run_instr(4'hE, 0, 0, 1'b0, 1'b0);         // illegal opcode halts
        run_instr(4'h9, 0, 0, 1'b0, 1'b1);         // reset during sw MEM
        run_instr(4'h9, 2, 1, 1'b0, 1'b0);         // sw after the abort
        run_instr(4'h8, 0, TIMEOUT, 1'b0, 1'b0);   // MEM timeout
        run_instr(4'hD, 0, 0, 1'b0, 1'b0);
        run_instr(4'hF, 0, 0, 1'b0, 1'b0);
        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t expected the run to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
